multicycle_control_unit: RTL

- Moore FSM that sequences the multicycle datapath around the unified instruction/data memory.
- Drives IorD, MemRead, MemWrite, IRWrite and the PC, register-file and ALU mux selects each cycle.
- Decodes the 6-bit opcode held in the instruction register.
- Supports lw, sw, R-type, beq, addi, j and halt; flags illegal opcodes.

---
 rtl/multicycle_control_unit.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// multicycle_control_unit
//
// Moore control FSM for a multicycle processor that shares one memory for
// instructions and data. Each state drives a fixed set of datapath controls;
// memory-access states (FETCH, MEMRD, MEMWR) can be stretched by MEM_WAIT
// extra cycles to match a slow memory.
//
// Parameters:
//   MEM_WAIT    extra wait cycles per memory-access state (0..15)
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous active-high reset -> IDLE, wait counter cleared
//   opcode      instr[31:26] from the instruction register
//   PCWrite     unconditional PC load
//   PCWriteCond PC load gated by ALU zero in the datapath
//   IorD        memory address select (0 = PC, 1 = ALUOut)
//   MemRead     memory read enable
//   MemWrite    memory write enable
//   IRWrite     instruction register load
//   MemtoReg    register write-data select (1 = MDR)
//   RegDst      destination register select (1 = rd, 0 = rt)
//   RegWrite    register file write enable
//   ALUSrcA     ALU A select (0 = PC, 1 = A)
//   ALUSrcB     ALU B select (00 = B, 01 = 4, 10 = signext, 11 = signext<<2)
//   ALUOp       00 = add, 01 = sub, 10 = funct field
//   PCSource    00 = ALU result, 01 = ALUOut, 10 = jump target
//   state_out   current state encoding (debug)
//   illegal_op  one-cycle pulse in DECODE for an undefined opcode
//   halted      high while in HALT
// -----------------------------------------------------------------------------
module multicycle_control_unit #(
    parameter int MEM_WAIT = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic [3:0] state_out,
    output logic       illegal_op,
    output logic       halted
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_RWB    = 4'd8,
        S_BRANCH = 4'd9,
        S_IEXEC  = 4'd10,
        S_IWB    = 4'd11,
        S_JUMP   = 4'd12,
        S_HALT   = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

    state_t     state_q, state_d;
    logic [3:0] wait_q,  wait_d;

    // High in the final cycle of a (possibly stretched) memory-access state.
    logic mem_last;
    assign mem_last = (wait_q == WAIT_LAST);

    function automatic logic is_legal(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_J, OP_BEQ, OP_ADDI,
            OP_LW, OP_SW, OP_HALT: is_legal = 1'b1;
            default:               is_legal = 1'b0;
        endcase
    endfunction

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            wait_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // The wait counter defaults to 0 so that every entry into a memory state
    // starts a fresh count; it only counts up while a memory state is held.
    always_comb begin
        state_d = state_q;
        wait_d  = 4'd0;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                if (mem_last) state_d = S_DECODE;
                else          wait_d  = wait_q + 4'd1;
            end
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_IEXEC;
                    OP_J:         state_d = S_JUMP;
                    OP_HALT:      state_d = S_HALT;
                    default:      state_d = S_FETCH;
                endcase
            end
            // The IR holds the opcode, so lw/sw is simply re-decoded here.
            // Anything else cannot reach MEMADR; recover by refetching.
            S_MEMADR: begin
                if (opcode == OP_LW)      state_d = S_MEMRD;
                else if (opcode == OP_SW) state_d = S_MEMWR;
                else                      state_d = S_FETCH;
            end
            S_MEMRD: begin
                if (mem_last) state_d = S_MEMWB;
                else          wait_d  = wait_q + 4'd1;
            end
            S_MEMWB: state_d = S_FETCH;
            S_MEMWR: begin
                if (mem_last) state_d = S_FETCH;
                else          wait_d  = wait_q + 4'd1;
            end
            S_EXEC:   state_d = S_RWB;
            S_RWB:    state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_IEXEC:  state_d = S_IWB;
            S_IWB:    state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IDLE;  // unused encodings 14/15
        endcase
    end

    // -------------------------------------------------------------------------
    // Output logic
    // -------------------------------------------------------------------------
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        illegal_op  = 1'b0;
        halted      = 1'b0;
        case (state_q)
            S_FETCH: begin
                // Read is held for the whole access; IR and PC load once,
                // when the data is valid in the last cycle.
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_last;
                PCWrite = mem_last;
            end
            S_DECODE: begin
                ALUSrcB    = 2'b11;
                illegal_op = ~is_legal(opcode);
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMRD: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
            end
            S_MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            S_MEMWR: begin
                // Single write strobe per store, at the end of the wait.
                IorD     = 1'b1;
                MemWrite = mem_last;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            S_RWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
            end
            S_IEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_IWB: begin
                RegWrite = 1'b1;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: ;
        endcase
    end

    assign state_out = state_q;

endmodule
